// File: rtl/fir_frame_sequencer.sv
// Front/back end for the block FIR engine: collects serial samples into a frame,
// launches the engine, guards it with a watchdog and replays its results serially.
module fir_frame_sequencer #(
   parameter int SAMPLES_NUM    = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                        clkIn,
   input  logic                        nResetIn,
   input  logic [15:0]                 sampleIn,
   input  logic                        sampleValidIn,
   output logic                        sampleReadyOut,
   output logic                        firStartOut,
   input  logic                        firBusyIn,
   input  logic                        firDoneIn,
   output logic [16*SAMPLES_NUM-1:0]   firDataOut,
   input  logic [32*SAMPLES_NUM-1:0]   firResultIn,
   output logic [31:0]                 resultOut,
   output logic                        resultValidOut,
   input  logic                        resultReadyIn,
   output logic [15:0]                 frameCountOut,
   output logic                        errorOut
);
   localparam int DATA_W = 16;
   localparam int RES_W  = 32;
   localparam int CNT_W  = $clog2(SAMPLES_NUM + 1);
   localparam int IDX_W  = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLES_NUM);
   localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(SAMPLES_NUM - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} seqStateT;

   seqStateT                     state;
   logic [CNT_W-1:0]             count;
   logic [CNT_W-1:0]             countNext;
   logic [DATA_W*SAMPLES_NUM-1:0] laneReg;
   logic [RES_W*SAMPLES_NUM-1:0] resultReg;
   logic [IDX_W-1:0]             idx;
   logic [IDX_W-1:0]             idxNext;
   logic [TMO_W-1:0]             tmoCnt;
   logic                         sampleFire;
   logic                         transfer;
   logic                         resultFire;

   always_comb begin
      sampleFire = sampleValidIn && sampleReadyOut;
      transfer   = (state == IDLE) && (count == FULL_CNT) && !firBusyIn;
      resultFire = resultValidOut && resultReadyIn;
      idxNext    = idx - IDX_W'(1);
      countNext  = count;
      if (transfer) begin
         countNext = '0;
      end else if (sampleFire) begin
         countNext = count + CNT_W'(1);
      end
   end

   // Collector: ready is registered from the next fill level so it reads 0 in reset.
   always_ff @(posedge clkIn or negedge nResetIn) begin
      if (!nResetIn) begin
         count          <= '0;
         sampleReadyOut <= 1'b0;
         laneReg        <= '0;
      end else begin
         count          <= countNext;
         sampleReadyOut <= (countNext < FULL_CNT);
         if (sampleFire) begin
            laneReg[DATA_W*count +: DATA_W] <= sampleIn;
         end
      end
   end

   // Engine control, watchdog and result replay (highest lane first).
   always_ff @(posedge clkIn or negedge nResetIn) begin
      if (!nResetIn) begin
         state          <= IDLE;
         firStartOut    <= 1'b0;
         firDataOut     <= '0;
         tmoCnt         <= '0;
         idx            <= '0;
         resultReg      <= '0;
         resultOut      <= '0;
         resultValidOut <= 1'b0;
         frameCountOut  <= '0;
         errorOut       <= 1'b0;
      end else begin
         firStartOut <= 1'b0;
         case (state)
            IDLE: begin
               if (transfer) begin
                  firDataOut  <= laneReg;
                  firStartOut <= 1'b1;
                  state       <= START;
               end
            end
            START: begin
               tmoCnt <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (firDoneIn) begin
                  resultReg      <= firResultIn;
                  resultOut      <= firResultIn[RES_W*(SAMPLES_NUM-1) +: RES_W];
                  idx            <= TOP_IDX;
                  resultValidOut <= 1'b1;
                  state          <= DRAIN;
               end else if (tmoCnt == TMO_LAST) begin
                  // Hung engine: drop the frame, remember it happened.
                  errorOut <= 1'b1;
                  state    <= IDLE;
               end else begin
                  tmoCnt <= tmoCnt + TMO_W'(1);
               end
            end
            DRAIN: begin
               if (resultFire) begin
                  if (idx == '0) begin
                     resultValidOut <= 1'b0;
                     frameCountOut  <= frameCountOut + 16'd1;
                     state          <= IDLE;
                  end else begin
                     idx       <= idxNext;
                     resultOut <= resultReg[RES_W*idxNext +: RES_W];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
